// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the gcd/lcm coprocessor.
//   state_t      : controller states
//   OP_GCD/OP_LCM: custom opcodes recognised by the decoder
//   ALUOP_COPROC : ALUOp value used for both opcodes
//   WIDTH_DEF    : default operand/result width
package gcd_lcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] OP_GCD       = 7'b0000000;
  localparam logic [6:0] OP_LCM       = 7'b0000001;
  localparam logic [2:0] ALUOP_COPROC = 3'b110;
  localparam int         WIDTH_DEF    = 32;

endpackage

// File: rtl/gcd_lcm_if.sv
// Issue/result bundle between the execute stage and the gcd/lcm unit.
//   start, op_lcm, a, b, kill : request side (driven by the pipeline)
//   busy, done, result, ovf   : response side (driven by the unit)
interface gcd_lcm_if
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic             op_lcm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    output start, op_lcm, a, b, kill,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, op_lcm, a, b, kill,
    output busy, done, result, ovf
  );

endinterface

// File: rtl/gcd_lcm_dp.sv
// Datapath for subtractive Euclid with lcm tracking.
// Invariant kept by the step rule: at termination x==y==gcd and
// (u+v)/2 == lcm, so only add/sub/compare hardware is needed.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   load, step, finish   : one-hot strobes from the controller
//   op_lcm, a, b         : request captured on load
//   fin_cond             : iteration finished (zero operand or x==y)
//   result, ovf          : registered outputs, written on finish
module gcd_lcm_dp #(
  parameter int WIDTH = 32,
  parameter int UVW   = 2*WIDTH+1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             op_lcm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin_cond,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH-1:0] x, y;
  logic [UVW-1:0]   u, v;
  logic             op_q;
  logic             zero_q;

  logic             x_gt_y;
  logic [UVW-1:0]   uv_sum;
  logic [UVW-1:0]   full;

  // u+v == v+u, so one adder serves both step directions and the lcm finish
  assign x_gt_y   = x > y;
  assign uv_sum   = u + v;
  assign full     = uv_sum >> 1;
  assign fin_cond = zero_q | (x == y);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= '0;
      ovf    <= 1'b0;
    end else if (load) begin
      x      <= a;
      y      <= b;
      u      <= {{(UVW-WIDTH){1'b0}}, b};
      v      <= {{(UVW-WIDTH){1'b0}}, a};
      op_q   <= op_lcm;
      zero_q <= (a == '0) | (b == '0);
    end else if (step) begin
      if (x_gt_y) begin
        x <= x - y;
        v <= uv_sum;
      end else begin
        y <= y - x;
        u <= uv_sum;
      end
    end else if (finish) begin
      if (op_q) begin
        result <= zero_q ? '0 : full[WIDTH-1:0];
        ovf    <= zero_q ? 1'b0 : |full[UVW-1:WIDTH];
      end else begin
        // with a zero operand no step ran, so the nonzero one (or 0) is still in x/y
        result <= (x == '0) ? y : x;
        ovf    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle gcd/lcm execution unit. Stalls the pipeline via busy while
// iterating and pulses done for one cycle with the registered result.
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : request/response bundle (slave side)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one Euclid step per cycle, busy high
// DONE  | result valid, done high for one cycle; start here re-issues
module gcd_lcm_unit
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  gcd_lcm_if.slave   bus
);

  state_t state;
  logic   busy_q;
  logic   done_q;
  logic   fin_cond;
  logic   load, step, finish;

  // kill and reset suppress every strobe so a flushed op never writes result
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    if (reset_n && !bus.kill) begin
      load   = bus.start && (state != RUN);
      step   = (state == RUN) && !fin_cond;
      finish = (state == RUN) && fin_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.kill) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (fin_cond) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  gcd_lcm_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .step     (step),
    .finish   (finish),
    .op_lcm   (bus.op_lcm),
    .a        (bus.a),
    .b        (bus.b),
    .fin_cond (fin_cond),
    .result   (bus.result),
    .ovf      (bus.ovf)
  );

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Directed bench for gcd_lcm_unit at WIDTH=8.
// Latency convention: "lat" is the number of edges after the issue edge E
// at which done is first seen high (N steps -> lat = N+1).
module tb_gcd_lcm_unit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  gcd_lcm_if #(.WIDTH(W)) bus ();

  gcd_lcm_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    int           lat;
  } vec_t;

  // call at #1 after an edge; returns #1 after the issue edge
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.op_lcm = op;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // measures edges until done; lat=-1 if the budget expires
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 600; i++) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vectors(input string tag, input vec_t vecs[$]);
    int lat, bc;
    foreach (vecs[k]) begin
      issue(vecs[k].op, vecs[k].a, vecs[k].b);
      wait_done(lat, bc);
      n_checks++;
      if (lat !== vecs[k].lat)
        $display("FAIL %s[%0d] latency: got %0d want %0d", tag, k, lat, vecs[k].lat);
      else n_pass++;
      n_checks++;
      if (bc !== vecs[k].lat)
        $display("FAIL %s[%0d] busy cycles: got %0d want %0d", tag, k, bc, vecs[k].lat);
      else n_pass++;
      n_checks++;
      if (bus.result !== vecs[k].res)
        $display("FAIL %s[%0d] result: got %0d want %0d", tag, k, bus.result, vecs[k].res);
      else n_pass++;
      n_checks++;
      if (bus.ovf !== vecs[k].ovf)
        $display("FAIL %s[%0d] ovf: got %0b want %0b", tag, k, bus.ovf, vecs[k].ovf);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL %s[%0d] after-done: got done=%0b busy=%0b want 0/0", tag, k, bus.done, bus.busy);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op_lcm = 1'b0; bus.a = '0; bus.b = '0; bus.kill = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || bus.result !== '0)
      $display("FAIL reset: got busy=%0b done=%0b ovf=%0b result=%0d want all 0",
               bus.busy, bus.done, bus.ovf, bus.result);
    else n_pass++;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_gcd();
    vec_t v[$];
    v.push_back('{1'b0, 8'd12,  8'd18, 8'd6,  1'b0, 3}); // y=6, x=6
    v.push_back('{1'b0, 8'd7,   8'd7,  8'd7,  1'b0, 1});
    v.push_back('{1'b0, 8'd100, 8'd75, 8'd25, 1'b0, 4}); // x=25, y=50, y=25
    run_vectors("gcd", v);
  endtask

  task automatic test_lcm();
    vec_t v[$];
    v.push_back('{1'b1, 8'd12, 8'd18, 8'd36, 1'b0, 3});
    v.push_back('{1'b1, 8'd7,  8'd7,  8'd7,  1'b0, 1});
    v.push_back('{1'b1, 8'd4,  8'd6,  8'd12, 1'b0, 3});
    // 255*254 = 64770 = 0xFD02; one x-step then 253 y-steps = 254 steps
    v.push_back('{1'b1, 8'd255, 8'd254, 8'h02, 1'b1, 255});
    run_vectors("lcm", v);
  endtask

  task automatic test_zero();
    vec_t v[$];
    v.push_back('{1'b0, 8'd0, 8'd7, 8'd7, 1'b0, 1});
    v.push_back('{1'b1, 8'd0, 8'd7, 8'd0, 1'b0, 1});
    v.push_back('{1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1});
    v.push_back('{1'b0, 8'd5, 8'd0, 8'd5, 1'b0, 1});
    v.push_back('{1'b1, 8'd9, 8'd0, 8'd0, 1'b0, 1});
    run_vectors("zero", v);
  endtask

  task automatic test_kill();
    int lat, bc;
    int seen;
    issue(1'b0, 8'd100, 8'd75);
    wait_done(lat, bc);
    n_checks++;
    if (bus.result !== 8'd25) $display("FAIL kill-pre result: got %0d want 25", bus.result);
    else n_pass++;
    @(posedge clk); #1;
    issue(1'b0, 8'd12, 8'd18);      // edge E
    @(posedge clk); #1;             // E+1
    bus.kill = 1'b1;
    @(posedge clk); #1;             // E+2 kill sampled
    bus.kill = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'd25 || bus.ovf !== 1'b0)
      $display("FAIL kill: got busy=%0b done=%0b result=%0d ovf=%0b want 0/0/25/0",
               bus.busy, bus.done, bus.result, bus.ovf);
    else n_pass++;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.done || bus.busy) seen++; end
    n_checks++;
    if (seen !== 0) $display("FAIL kill-quiet: got %0d active cycles want 0", seen);
    else n_pass++;
    issue(1'b0, 8'd9, 8'd6);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 3 || bus.result !== 8'd3)
      $display("FAIL kill-next: got lat=%0d result=%0d want 3/3", lat, bus.result);
    else n_pass++;
    @(posedge clk); #1;
    // kill together with start: start dropped
    bus.kill = 1'b1;
    issue(1'b1, 8'd4, 8'd6);
    bus.kill = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done || bus.busy) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0 || bus.result !== 8'd3)
      $display("FAIL kill-start: got active=%0d result=%0d want 0/3", seen, bus.result);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    int seen;
    issue(1'b0, 8'd12, 8'd18);
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd75;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 2 || bus.result !== 8'd6)   // one edge already consumed by the stray start
      $display("FAIL ignore-start: got lat=%0d result=%0d want 2/6", lat, bus.result);
    else n_pass++;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.done || bus.busy) seen++; end
    n_checks++;
    if (seen !== 0) $display("FAIL ignore-start queued: got %0d active cycles want 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(1'b1, 8'd12, 8'd18);
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || bus.result !== '0)
      $display("FAIL reset-mid: got busy=%0b done=%0b ovf=%0b result=%0d want all 0",
               bus.busy, bus.done, bus.ovf, bus.result);
    else n_pass++;
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.done || bus.busy) seen++; end
    n_checks++;
    if (seen !== 0 || bus.result !== '0)
      $display("FAIL reset-mid quiet: got active=%0d result=%0d want 0/0", seen, bus.result);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(1'b0, 8'd12, 8'd18);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 3 || bus.result !== 8'd6)
      $display("FAIL b2b first: got lat=%0d result=%0d want 3/6", lat, bus.result);
    else n_pass++;
    issue(1'b1, 8'd4, 8'd6);       // start sampled in the DONE cycle
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL b2b rerun: got busy=%0b done=%0b want 1/0", bus.busy, bus.done);
    else n_pass++;
    wait_done(lat, bc);
    n_checks++;
    if (lat !== 3 || bus.result !== 8'd12 || bus.ovf !== 1'b0)
      $display("FAIL b2b second: got lat=%0d result=%0d ovf=%0b want 3/12/0", lat, bus.result, bus.ovf);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL b2b pulse: got done=%0b want 0", bus.done);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_gcd();
    test_lcm();
    test_zero();
    test_kill();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
